// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the multiport register file
package regfile_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_READ   = 2;
    typedef enum logic {IDLE, CLEAR} regfile_state_t;
endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sweeps every entry to zero after reset or a clear request, one entry per cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clear_we,
    output logic [ADDR_WIDTH-1:0] o_clear_idx
);
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    regfile_state_t        r_state;
    regfile_state_t        w_next_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_next_idx;
    // State and sweep index; reset restarts the sweep from entry 0 even mid-sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end
    // Sweep ends after the last entry; clear is ignored while already sweeping
    always_comb begin
        w_next_state = (r_state == CLEAR) ? ((r_idx == LAST) ? IDLE : CLEAR) : (i_clear ? CLEAR : IDLE);
        w_next_idx   = (r_state == CLEAR) ? r_idx + ADDR_WIDTH'(1) : '0;
    end
    assign o_busy      = (r_state == CLEAR);
    assign o_clear_we  = (r_state == CLEAR);
    assign o_clear_idx = r_idx;
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: N-read / 2-write register file with optional zero register and clear sweep
// Define REGFILE_BYPASS_EN to forward committing write data to matching reads in the same cycle.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic [ADDR_WIDTH-1:0]          write_address_0,
    input  logic [DATA_WIDTH-1:0]          write_data_0,
    input  logic                           write_enable_0,
    input  logic [ADDR_WIDTH-1:0]          write_address_1,
    input  logic [DATA_WIDTH-1:0]          write_data_1,
    input  logic                           write_enable_1,
    input  logic                           clear,
    output logic                           busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_clear_we;
    logic [ADDR_WIDTH-1:0] w_clear_idx;
    logic                  w_wr_ok;
    logic                  w_commit_0;
    logic                  w_commit_1;
    regfile_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .o_busy      (busy),
        .o_clear_we  (w_clear_we),
        .o_clear_idx (w_clear_idx)
    );
    assign w_wr_ok    = !busy && !clear && !rst;
    assign w_commit_0 = write_enable_0 && w_wr_ok && !((ZERO_REG != 0) && (write_address_0 == '0));
    assign w_commit_1 = write_enable_1 && w_wr_ok && !((ZERO_REG != 0) && (write_address_1 == '0));
    // Sweep zeroing has absolute priority; port 1 is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[w_clear_idx] <= '0;
        end else begin
            if (w_commit_0) r_mem[write_address_0] <= write_data_0;
            if (w_commit_1) r_mem[write_address_1] <= write_data_1;
        end
    end
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_val;
        assign w_addr = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
        assign w_val = (w_commit_1 && write_address_1 == w_addr) ? write_data_1 :
                       (w_commit_0 && write_address_0 == w_addr) ? write_data_0 : r_mem[w_addr];
`else
        assign w_val = r_mem[w_addr];
`endif
        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] =
            (busy || ((ZERO_REG != 0) && (w_addr == '0))) ? '0 : w_val;
    end
endmodule
